// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared state encoding, command indices and timing defaults for the servo scan sequencer
package servo_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ZERO      = 4'd1,
    ST_WAIT_ZERO = 4'd2,
    ST_SWEEP     = 4'd3,
    ST_WAIT_X    = 4'd4,
    ST_STEP      = 4'd5,
    ST_WAIT_Y    = 4'd6,
    ST_RETURN    = 4'd7,
    ST_WAIT_RTZ  = 4'd8
  } scan_state_t;

  // Bit positions of the per-axis command vector
  localparam int CMD_W       = 5;
  localparam int CMD_NEUTRAL = 0;
  localparam int CMD_FORWARD = 1;
  localparam int CMD_REVERSE = 2;
  localparam int CMD_ZERO    = 3;
  localparam int CMD_RTZ     = 4;

  // 20 ms servo frame at 100 MHz; the wait watchdog allows 200 frames (4 s)
  localparam int unsigned PWM_PERIOD_CYCLES  = 2_000_000;
  localparam int unsigned DEFAULT_WAIT_LIMIT = 200 * PWM_PERIOD_CYCLES;

  // One-hot command vector with only the requested command set
  function automatic logic [CMD_W-1:0] cmd_pulse(input int idx);
    return CMD_W'(1) << idx;
  endfunction

endpackage

// File: rtl/scan_watchdog.sv
// rtl/scan_watchdog.sv - loadable down-counter flagging too long a stay in one scan state
module scan_watchdog #(
  parameter int unsigned LIMIT = 400_000_000
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic load,
  output logic expired
);

  localparam int WD_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [WD_W-1:0] LOAD_VAL = WD_W'(LIMIT - 1);

  logic [WD_W-1:0] cnt;

  // Reload on every state entry, otherwise count down and hold at zero
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      cnt <= '0;
    else if (load)
      cnt <= LOAD_VAL;
    else if (cnt != '0)
      cnt <= cnt - WD_W'(1);
  end

  // Zero is reached in the LIMIT-th cycle after the load
  assign expired = (cnt == '0);

endmodule

// File: rtl/servo_scan_sequencer.sv
// rtl/servo_scan_sequencer.sv - boustrophedon raster scan sequencer for a pan/tilt servo pair
module servo_scan_sequencer
  import servo_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int          ROW_W      = 8,
  parameter int unsigned WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_x_span,
  input  logic [CNT_W-1:0] cfg_y_step,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic [CNT_W-1:0] x_fwd_cnt,
  input  logic [CNT_W-1:0] x_rev_cnt,
  input  logic [CNT_W-1:0] y_fwd_cnt,
  input  logic [CNT_W-1:0] y_rev_cnt,
  input  logic             x_in_rtz,
  input  logic             y_in_rtz,
  output logic             x_cmd_neutral,
  output logic             x_cmd_forward,
  output logic             x_cmd_reverse,
  output logic             x_cmd_zero,
  output logic             x_cmd_rtz,
  output logic             y_cmd_neutral,
  output logic             y_cmd_forward,
  output logic             y_cmd_reverse,
  output logic             y_cmd_zero,
  output logic             y_cmd_rtz,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [ROW_W-1:0] row_idx
);

  scan_state_t state, state_nxt;
  logic [CNT_W-1:0] span_q, span_nxt, step_q, step_nxt;
  logic [ROW_W-1:0] rows_q, rows_nxt, row_q, row_nxt;
  logic             fault_q, fault_nxt, done_q, done_nxt;
  logic [CMD_W-1:0] x_cmd_q, x_cmd_nxt, y_cmd_q, y_cmd_nxt;
  logic signed [CNT_W:0] x_pos, y_pos, span_s, y_target_s;
  logic [CNT_W-1:0] y_target;
  logic             in_wait, wd_expired;

  // Positions carry one extra bit so a reverse overshoot reads as negative
  assign x_pos      = $signed({1'b0, x_fwd_cnt}) - $signed({1'b0, x_rev_cnt});
  assign y_pos      = $signed({1'b0, y_fwd_cnt}) - $signed({1'b0, y_rev_cnt});
  assign span_s     = $signed({1'b0, span_q});
  assign y_target   = (CNT_W'(row_q) + CNT_W'(1)) * step_q;
  assign y_target_s = $signed({1'b0, y_target});
  assign in_wait    = (state == ST_WAIT_ZERO) || (state == ST_WAIT_X) ||
                      (state == ST_WAIT_Y)    || (state == ST_WAIT_RTZ);

  scan_watchdog #(.LIMIT(WAIT_LIMIT)) u_watchdog (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .load    (state_nxt != state),
    .expired (wd_expired)
  );

  // Registered state, latched geometry, status flags and command pulses
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      span_q  <= '0;
      step_q  <= '0;
      rows_q  <= '0;
      row_q   <= '0;
      fault_q <= 1'b0;
      done_q  <= 1'b0;
      x_cmd_q <= '0;
      y_cmd_q <= '0;
    end else begin
      state   <= state_nxt;
      span_q  <= span_nxt;
      step_q  <= step_nxt;
      rows_q  <= rows_nxt;
      row_q   <= row_nxt;
      fault_q <= fault_nxt;
      done_q  <= done_nxt;
      x_cmd_q <= x_cmd_nxt;
      y_cmd_q <= y_cmd_nxt;
    end
  end

  // Next-state and next-command decode; abort beats the watchdog, both beat normal flow
  always_comb begin
    state_nxt = state;
    span_nxt  = span_q;
    step_nxt  = step_q;
    rows_nxt  = rows_q;
    row_nxt   = row_q;
    fault_nxt = fault_q;
    done_nxt  = 1'b0;
    x_cmd_nxt = '0;
    y_cmd_nxt = '0;
    if (state != ST_IDLE && abort) begin
      x_cmd_nxt = cmd_pulse(CMD_NEUTRAL);
      y_cmd_nxt = cmd_pulse(CMD_NEUTRAL);
      state_nxt = ST_IDLE;
    end else if (in_wait && wd_expired) begin
      x_cmd_nxt = cmd_pulse(CMD_NEUTRAL);
      y_cmd_nxt = cmd_pulse(CMD_NEUTRAL);
      fault_nxt = 1'b1;
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            span_nxt  = cfg_x_span;
            step_nxt  = cfg_y_step;
            rows_nxt  = cfg_rows;
            row_nxt   = '0;
            fault_nxt = 1'b0;
            if (cfg_rows == '0 || cfg_x_span == '0)
              done_nxt = 1'b1;
            else
              state_nxt = ST_ZERO;
          end
        end
        ST_ZERO: begin
          x_cmd_nxt = cmd_pulse(CMD_ZERO);
          y_cmd_nxt = cmd_pulse(CMD_ZERO);
          state_nxt = ST_WAIT_ZERO;
        end
        ST_WAIT_ZERO: begin
          if (x_fwd_cnt == '0 && x_rev_cnt == '0 && y_fwd_cnt == '0 && y_rev_cnt == '0)
            state_nxt = ST_SWEEP;
        end
        ST_SWEEP: begin
          x_cmd_nxt = row_q[0] ? cmd_pulse(CMD_REVERSE) : cmd_pulse(CMD_FORWARD);
          state_nxt = ST_WAIT_X;
        end
        ST_WAIT_X: begin
          if (row_q[0] ? (x_pos <= 0) : (x_pos >= span_s)) begin
            x_cmd_nxt = cmd_pulse(CMD_NEUTRAL);
            state_nxt = (row_q == rows_q - ROW_W'(1)) ? ST_RETURN : ST_STEP;
          end
        end
        ST_STEP: begin
          y_cmd_nxt = cmd_pulse(CMD_FORWARD);
          state_nxt = ST_WAIT_Y;
        end
        ST_WAIT_Y: begin
          if (y_pos >= y_target_s) begin
            y_cmd_nxt = cmd_pulse(CMD_NEUTRAL);
            row_nxt   = row_q + ROW_W'(1);
            state_nxt = ST_SWEEP;
          end
        end
        ST_RETURN: begin
          x_cmd_nxt = cmd_pulse(CMD_RTZ);
          y_cmd_nxt = cmd_pulse(CMD_RTZ);
          state_nxt = ST_WAIT_RTZ;
        end
        ST_WAIT_RTZ: begin
          if (x_pos == 0 && y_pos == 0 && !x_in_rtz && !y_in_rtz) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign x_cmd_neutral = x_cmd_q[CMD_NEUTRAL];
  assign x_cmd_forward = x_cmd_q[CMD_FORWARD];
  assign x_cmd_reverse = x_cmd_q[CMD_REVERSE];
  assign x_cmd_zero    = x_cmd_q[CMD_ZERO];
  assign x_cmd_rtz     = x_cmd_q[CMD_RTZ];
  assign y_cmd_neutral = y_cmd_q[CMD_NEUTRAL];
  assign y_cmd_forward = y_cmd_q[CMD_FORWARD];
  assign y_cmd_reverse = y_cmd_q[CMD_REVERSE];
  assign y_cmd_zero    = y_cmd_q[CMD_ZERO];
  assign y_cmd_rtz     = y_cmd_q[CMD_RTZ];
  assign busy          = (state != ST_IDLE);
  assign done          = done_q;
  assign fault         = fault_q;
  assign row_idx       = row_q;

endmodule

// File: tb/tb_servo_scan_sequencer.sv
// tb/tb_servo_scan_sequencer.sv - scoreboard bench for the servo scan sequencer with behavioural servos
`timescale 1ns/1ps
module tb_servo_scan_sequencer;

  localparam int PER   = 50;
  localparam int WL    = 500;
  localparam int NOCHK = -99999;
  // command codes = bit position in the vectors built below
  localparam int C_NEU = 0, C_FWD = 1, C_REV = 2, C_ZERO = 3, C_RTZ = 4;

  logic        PCLK = 1'b0, PRESET = 1'b1, start = 1'b0, abort = 1'b0;
  logic [31:0] cfg_x_span = '0, cfg_y_step = '0;
  logic [7:0]  cfg_rows = '0;
  logic [31:0] x_fwd_cnt, x_rev_cnt, y_fwd_cnt, y_rev_cnt;
  logic        x_in_rtz, y_in_rtz;
  logic        x_cmd_neutral, x_cmd_forward, x_cmd_reverse, x_cmd_zero, x_cmd_rtz;
  logic        y_cmd_neutral, y_cmd_forward, y_cmd_reverse, y_cmd_zero, y_cmd_rtz;
  logic        busy, done, fault;
  logic [7:0]  row_idx;

  always #5 PCLK = ~PCLK;

  servo_scan_sequencer #(.CNT_W(32), .ROW_W(8), .WAIT_LIMIT(WL)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .abort(abort),
    .cfg_x_span(cfg_x_span), .cfg_y_step(cfg_y_step), .cfg_rows(cfg_rows),
    .x_fwd_cnt(x_fwd_cnt), .x_rev_cnt(x_rev_cnt), .y_fwd_cnt(y_fwd_cnt), .y_rev_cnt(y_rev_cnt),
    .x_in_rtz(x_in_rtz), .y_in_rtz(y_in_rtz),
    .x_cmd_neutral(x_cmd_neutral), .x_cmd_forward(x_cmd_forward), .x_cmd_reverse(x_cmd_reverse),
    .x_cmd_zero(x_cmd_zero), .x_cmd_rtz(x_cmd_rtz),
    .y_cmd_neutral(y_cmd_neutral), .y_cmd_forward(y_cmd_forward), .y_cmd_reverse(y_cmd_reverse),
    .y_cmd_zero(y_cmd_zero), .y_cmd_rtz(y_cmd_rtz),
    .busy(busy), .done(done), .fault(fault), .row_idx(row_idx)
  );

  logic [4:0] xcv, ycv;
  assign xcv = {x_cmd_rtz, x_cmd_zero, x_cmd_reverse, x_cmd_forward, x_cmd_neutral};
  assign ycv = {y_cmd_rtz, y_cmd_zero, y_cmd_reverse, y_cmd_forward, y_cmd_neutral};

  // ---------------- behavioural tracking servos (index 0 = X, 1 = Y) ----------------
  int   m_fwd [2];
  int   m_rev [2];
  int   m_mode[2];   // 0 neutral, 1 forward, 2 reverse, 3 return-to-zero
  int   m_ph  [2];
  logic m_rtz [2];
  logic ignore_x = 1'b0;

  function automatic logic hc(input int a, input int i);
    logic [4:0] v;
    v = (a == 0) ? xcv : ycv;
    return v[i];
  endfunction

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int a = 0; a < 2; a++) begin
        m_fwd[a] <= 0; m_rev[a] <= 0; m_mode[a] <= 0; m_ph[a] <= 0; m_rtz[a] <= 1'b0;
      end
    end else begin
      for (int a = 0; a < 2; a++) begin
        if (!(a == 0 && ignore_x) && hc(a, C_ZERO)) begin
          m_fwd[a] <= 0; m_rev[a] <= 0; m_mode[a] <= 0; m_ph[a] <= 0; m_rtz[a] <= 1'b0;
        end else if (!(a == 0 && ignore_x) && hc(a, C_NEU)) begin
          m_mode[a] <= 0;
        end else if (!(a == 0 && ignore_x) && hc(a, C_FWD)) begin
          m_mode[a] <= 1; m_ph[a] <= 0;
        end else if (!(a == 0 && ignore_x) && hc(a, C_REV)) begin
          m_mode[a] <= 2; m_ph[a] <= 0;
        end else if (!(a == 0 && ignore_x) && hc(a, C_RTZ)) begin
          m_mode[a] <= 3; m_ph[a] <= 0; m_rtz[a] <= 1'b1;
        end else if (m_mode[a] != 0) begin
          if (m_ph[a] == PER - 1) begin
            m_ph[a] <= 0;
            if (m_mode[a] == 1) m_fwd[a] <= m_fwd[a] + 1;
            else if (m_mode[a] == 2) m_rev[a] <= m_rev[a] + 1;
            else if (m_fwd[a] == m_rev[a]) begin
              m_fwd[a] <= 0; m_rev[a] <= 0; m_mode[a] <= 0; m_rtz[a] <= 1'b0;
            end else if (m_fwd[a] > m_rev[a]) m_rev[a] <= m_rev[a] + 1;
            else m_fwd[a] <= m_fwd[a] + 1;
          end else begin
            m_ph[a] <= m_ph[a] + 1;
          end
        end
      end
    end
  end

  assign x_fwd_cnt = 32'(m_fwd[0]);
  assign x_rev_cnt = 32'(m_rev[0]);
  assign y_fwd_cnt = 32'(m_fwd[1]);
  assign y_rev_cnt = 32'(m_rev[1]);
  assign x_in_rtz  = m_rtz[0];
  assign y_in_rtz  = m_rtz[1];

  // ---------------- scoreboard ----------------
  typedef struct { int cmd; int row; int pos; } exp_t;
  exp_t xq[$];
  exp_t yq[$];
  int   done_exp = 0;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // Expected command stream of a complete raster scan, derived from the scan geometry
  task automatic push_scan(input int span, input int step, input int rows);
    exp_t e;
    e = '{C_ZERO, -1, NOCHK}; xq.push_back(e); yq.push_back(e);
    for (int r = 0; r < rows; r++) begin
      e = '{(r % 2 == 1) ? C_REV : C_FWD, r, NOCHK};      xq.push_back(e);
      e = '{C_NEU, -1, (r % 2 == 1) ? 0 : span};          xq.push_back(e);
      if (r < rows - 1) begin
        e = '{C_FWD, r, NOCHK};                            yq.push_back(e);
        e = '{C_NEU, -1, (r + 1) * step};                  yq.push_back(e);
      end
    end
    e = '{C_RTZ, -1, NOCHK}; xq.push_back(e); yq.push_back(e);
    done_exp++;
  endtask

  task automatic mon_axis(input int a, input logic [4:0] v);
    exp_t e;
    int   code;
    string ax;
    ax = (a == 0) ? "x" : "y";
    if (v == 5'd0) return;
    chk({ax, "_cmd_onehot"}, $countones(v), 1);
    code = 0;
    for (int i = 4; i >= 0; i--) if (v[i]) code = i;
    if ((a == 0) ? (xq.size() == 0) : (yq.size() == 0)) begin
      $display("FAIL %s_unexpected_cmd: got code %0d, expected no command", ax, code);
      n_chk++; n_fail++;
    end else begin
      e = (a == 0) ? xq.pop_front() : yq.pop_front();
      chk({ax, "_cmd_code"}, code, e.cmd);
      if (e.row >= 0) chk({ax, "_cmd_row_idx"}, row_idx, e.row);
      if (e.pos != NOCHK) chk({ax, "_pos_at_cmd"}, m_fwd[a] - m_rev[a], e.pos);
    end
  endtask

  // Monitor: compare every command pulse and done pulse against the queued expectations
  always @(negedge PCLK) begin
    if (!PRESET) begin
      mon_axis(0, xcv);
      mon_axis(1, ycv);
      if (done) begin
        chk("done_expected", (done_exp > 0) ? 1 : 0, 1);
        if (done_exp > 0) done_exp--;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_start(input int span, input int step, input int rows);
    cfg_x_span = 32'(span); cfg_y_step = 32'(step); cfg_rows = 8'(rows);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 6000) begin tick(); n++; end
    if (busy) fail({nm, "_scan_timeout"});
  endtask

  task automatic wait_pulse(input int sel, input string nm);
    int n = 0;
    while (!((sel == 0) ? x_cmd_forward : (sel == 1) ? x_cmd_reverse : y_cmd_forward) && n < 4000) begin
      tick(); n++;
    end
    if (n >= 4000) fail({nm, "_pulse_timeout"});
  endtask

  task automatic drain(input string nm);
    repeat (3) tick();
    chk({nm, "_x_expect_left"}, xq.size(), 0);
    chk({nm, "_y_expect_left"}, yq.size(), 0);
    chk({nm, "_done_left"}, done_exp, 0);
  endtask

  task automatic check_home(input string nm);
    chk({nm, "_x_fwd_cnt"}, x_fwd_cnt, 0);
    chk({nm, "_x_rev_cnt"}, x_rev_cnt, 0);
    chk({nm, "_y_fwd_cnt"}, y_fwd_cnt, 0);
    chk({nm, "_y_rev_cnt"}, y_rev_cnt, 0);
  endtask

  task automatic full_scan(input string nm, input int span, input int step, input int rows);
    push_scan(span, step, rows);
    do_start(span, step, rows);
    chk({nm, "_busy_after_start"}, busy, 1);
    wait_idle(nm);
    drain(nm);
    check_home(nm);
    chk({nm, "_fault"}, fault, 0);
  endtask

  initial begin
    int sx, sy, sr, cnt_snap[4], n;

    // reset values
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_cmds", {xcv, ycv}, 0);
    PRESET = 1'b0;
    repeat (2) tick();

    // reference scan
    full_scan("scan_4_2_3", 4, 2, 3);

    // random geometries
    for (int i = 0; i < 4; i++) begin
      sx = $urandom_range(1, 6); sy = $urandom_range(1, 3); sr = $urandom_range(1, 3);
      full_scan("scan_rand", sx, sy, sr);
    end

    // empty scans: done one cycle later, no commands, never busy
    for (int k = 0; k < 2; k++) begin
      done_exp++;
      if (k == 0) do_start(5, 2, 0); else do_start(0, 2, 2);
      chk("empty_done_pulse", done, 1);
      chk("empty_busy", busy, 0);
      tick();
      chk("empty_done_single", done, 0);
      chk("empty_busy_later", busy, 0);
      drain("empty");
    end

    // start and abort together from IDLE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    repeat (5) tick();
    chk("start_abort_busy", busy, 0);
    drain("start_abort");

    // start while busy and cfg changes mid-scan are ignored
    push_scan(3, 2, 2);
    do_start(3, 2, 2);
    repeat (20) tick();
    do_start(6, 3, 3);
    chk("restart_busy", busy, 1);
    wait_idle("restart");
    drain("restart");
    check_home("restart");

    // watchdog: X ignores commands, times out in WAIT_X
    ignore_x = 1'b1;
    begin
      exp_t e;
      e = '{C_ZERO, -1, NOCHK}; xq.push_back(e); yq.push_back(e);
      e = '{C_FWD, 0, NOCHK};   xq.push_back(e);
      e = '{C_NEU, -1, NOCHK};  xq.push_back(e); yq.push_back(e);
    end
    do_start(4, 2, 3);
    wait_pulse(0, "wd_fwd");
    n = 0;
    while (!fault && n < 1000) begin tick(); n++; end
    chk("wd_cycles_in_wait_x", n, WL);
    chk("wd_fault", fault, 1);
    chk("wd_busy", busy, 0);
    chk("wd_x_neutral", x_cmd_neutral, 1);
    chk("wd_y_neutral", y_cmd_neutral, 1);
    drain("wd");
    chk("wd_fault_sticky", fault, 1);
    ignore_x = 1'b0;
    push_scan(2, 1, 2);
    do_start(2, 1, 2);
    chk("wd_fault_cleared", fault, 0);
    wait_idle("wd_recover");
    drain("wd_recover");
    check_home("wd_recover");

    // abort during row 1 WAIT_X
    push_scan(4, 2, 3);
    do_start(4, 2, 3);
    wait_pulse(1, "abort_rev");
    repeat (30) tick();
    xq.delete(); yq.delete(); done_exp = 0;
    begin
      exp_t e;
      e = '{C_NEU, -1, NOCHK}; xq.push_back(e); yq.push_back(e);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_x_neutral", x_cmd_neutral, 1);
    chk("abort_y_neutral", y_cmd_neutral, 1);
    chk("abort_busy", busy, 0);
    cnt_snap[0] = m_fwd[0]; cnt_snap[1] = m_rev[0]; cnt_snap[2] = m_fwd[1]; cnt_snap[3] = m_rev[1];
    repeat (100) tick();
    chk("abort_x_frozen", m_fwd[0] - m_rev[0], cnt_snap[0] - cnt_snap[1]);
    chk("abort_y_frozen", m_fwd[1] - m_rev[1], cnt_snap[2] - cnt_snap[3]);
    chk("abort_fault", fault, 0);
    drain("abort");

    // reset mid-scan in WAIT_Y
    push_scan(3, 2, 3);
    do_start(3, 2, 3);
    wait_pulse(2, "rst_yfwd");
    repeat (20) tick();
    PRESET = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_fault", fault, 0);
    chk("midrst_row_idx", row_idx, 0);
    chk("midrst_cmds", {xcv, ycv}, 0);
    xq.delete(); yq.delete(); done_exp = 0;
    repeat (3) tick();
    PRESET = 1'b0;
    repeat (2) tick();
    full_scan("post_reset", 5, 3, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

endmodule
